rr_handshake_arbiter: RTL and testbench

//  Parametrised N-input round-robin output arbiter for a router output port.

---
 rtl/rr_handshake_arbiter.sv | 151 +++++++++++++++
 tb/tb_rr_handshake_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_handshake_arbiter.sv
// Round-robin output-port arbiter: picks one requesting input, drives a one-hot crossbar select and handshakes flits downstream.
// Latency: owner registered one cycle after arbitration; RTS registered together with the new owner; grant is combinational.
// Backpressure: DCTS low while RTS is high stalls and freezes all state; req is ignored until the stall ends.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   req        per-input level request
//   DCTS       downstream clear-to-send
//   grant      one-hot flit-accept strobe to the owning input (owner & RTS & DCTS)
//   Xbar_sel   one-hot crossbar select, zero when idle
//   RTS        registered request-to-send
//   owner_idx  binary index of the current owner, zero when idle
module rr_handshake_arbiter #(
  parameter  int NUM_PORTS  = 5,
  parameter  int HOLD_LIMIT = 8,
  parameter  int STREAM     = 0,
  localparam int IDXW       = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 DCTS,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] Xbar_sel,
  output logic                 RTS,
  output logic [IDXW-1:0]      owner_idx
);

  localparam int CNTW = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [CNTW-1:0] HOLD_MAX = CNTW'(HOLD_LIMIT);
  localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  logic [NUM_PORTS-1:0] owner_q, owner_d;
  logic                 rts_q, rts_d;
  logic [CNTW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;

  logic                 transfer;
  logic                 stall;
  logic                 owner_vld;
  logic [IDXW-1:0]      owner_bin;
  logic [IDXW-1:0]      owner_succ;
  logic [CNTW-1:0]      cnt_next;
  logic                 others_req;
  logic                 hold_ok;
  logic [IDXW-1:0]      scan_start;
  logic                 scan_found;
  logic [IDXW-1:0]      scan_idx;

  assign transfer  = rts_q & DCTS;
  assign stall     = rts_q & ~DCTS;
  assign owner_vld = |owner_q;

  // owner_q is one-hot, so OR-ing the set indices yields its binary index.
  always_comb begin : owner_enc
    owner_bin = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (owner_q[i]) owner_bin = owner_bin | IDXW'(i);
    end
  end

  assign owner_succ = (owner_bin == IDXW'(NUM_PORTS - 1)) ? '0 : owner_bin + IDXW'(1);

  // Transfers to the current owner, saturating so a long-held owner cannot wrap back under the limit.
  always_comb begin : cnt_calc
    if (HOLD_LIMIT == 0) begin
      cnt_next = '0;
    end else if (hold_cnt_q == HOLD_MAX) begin
      cnt_next = HOLD_MAX;
    end else begin
      cnt_next = hold_cnt_q + CNTW'(transfer);
    end
  end

  assign others_req = |(req & ~owner_q);
  assign hold_ok    = (HOLD_LIMIT == 0) || (cnt_next < HOLD_MAX) || !others_req;

  // Idle searches from rr_ptr; an owner that must yield searches from its successor,
  // which naturally visits the owner itself last.
  assign scan_start = owner_vld ? owner_succ : rr_ptr_q;

  always_comb begin : rr_scan
    int              j;
    logic [IDXW-1:0] jj;
    scan_found = 1'b0;
    scan_idx   = '0;
    j          = 0;
    jj         = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = int'(scan_start) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      jj = IDXW'(j);
      if (!scan_found && req[jj]) begin
        scan_found = 1'b1;
        scan_idx   = jj;
      end
    end
  end

  always_comb begin : next_state
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    rts_d      = rts_q;
    if (!stall) begin
      if (!owner_vld) begin
        // Leaving idle does not move rr_ptr.
        owner_d    = scan_found ? (ONE << scan_idx) : '0;
        hold_cnt_d = '0;
      end else if (((req & owner_q) != '0) && hold_ok) begin
        hold_cnt_d = cnt_next;
      end else begin
        owner_d    = scan_found ? (ONE << scan_idx) : '0;
        hold_cnt_d = '0;
        rr_ptr_d   = owner_succ;
      end

      if (owner_d == '0) begin
        rts_d = 1'b0;
      end else if (transfer && (STREAM == 0)) begin
        // Non-streaming mode inserts one dead cycle after every flit.
        rts_d = 1'b0;
      end else begin
        rts_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= '0;
      rts_q      <= 1'b0;
      hold_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      owner_q    <= owner_d;
      rts_q      <= rts_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // The grant of a transfer cycle always belongs to the registered owner,
  // even when that same cycle hands ownership to someone else.
  assign Xbar_sel  = owner_q;
  assign grant     = owner_q & {NUM_PORTS{transfer}};
  assign RTS       = rts_q;
  assign owner_idx = owner_bin;

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Bench for rr_handshake_arbiter: two instances (HOLD_LIMIT=0/STREAM=0 and HOLD_LIMIT=2/STREAM=1) share req/DCTS.
// Latency: expected outputs are pushed per cycle from a behavioural model and popped mid-cycle against the DUTs.
// Backpressure: DCTS is driven directly, including held-low stall windows and random toggling.
module tb_rr_handshake_arbiter;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         dcts = 1'b0;

  logic [N-1:0] grant_a, xbar_a, grant_b, xbar_b;
  logic         rts_a, rts_b;
  logic [2:0]   idx_a, idx_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_handshake_arbiter #(.NUM_PORTS(N), .HOLD_LIMIT(0), .STREAM(0)) dut_a (
    .clk       (clk),
    .rst       (rst_n),
    .req       (req),
    .DCTS      (dcts),
    .grant     (grant_a),
    .Xbar_sel  (xbar_a),
    .RTS       (rts_a),
    .owner_idx (idx_a)
  );

  rr_handshake_arbiter #(.NUM_PORTS(N), .HOLD_LIMIT(2), .STREAM(1)) dut_b (
    .clk       (clk),
    .rst       (rst_n),
    .req       (req),
    .DCTS      (dcts),
    .grant     (grant_b),
    .Xbar_sel  (xbar_b),
    .RTS       (rts_b),
    .owner_idx (idx_b)
  );

  typedef struct {
    int owner;  // -1 when idle
    bit rts;
    int cnt;
    int ptr;
  } mst_t;

  typedef struct packed {
    logic [4:0] xbar;
    logic [4:0] grant;
    logic       rts;
    logic [2:0] idx;
  } exp_t;

  mst_t st_a, st_b;
  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic mst_t m_reset();
    mst_t s;
    s.owner = -1;
    s.rts   = 1'b0;
    s.cnt   = 0;
    s.ptr   = 0;
    return s;
  endfunction

  function automatic int first_req(input logic [4:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic mst_t m_next(input mst_t s, input logic [4:0] r, input logic d,
                                  input int hold, input int stream);
    mst_t n;
    bit   xfer;
    int   cn;
    logic [4:0] others;
    n    = s;
    xfer = s.rts && d;
    if (s.rts && !d) return s;
    cn = s.cnt + (xfer ? 1 : 0);
    if (cn > hold) cn = hold;
    if (s.owner < 0) begin
      n.owner = first_req(r, s.ptr);
      n.cnt   = 0;
    end else begin
      others = r;
      others[s.owner] = 1'b0;
      if (r[s.owner] && (hold == 0 || cn < hold || others == 5'b0)) begin
        n.cnt = cn;
      end else begin
        n.owner = first_req(r, (s.owner + 1) % N);
        n.cnt   = 0;
        n.ptr   = (s.owner + 1) % N;
      end
    end
    if (n.owner < 0)              n.rts = 1'b0;
    else if (xfer && stream == 0) n.rts = 1'b0;
    else                          n.rts = 1'b1;
    return n;
  endfunction

  function automatic exp_t m_out(input mst_t s, input logic d);
    exp_t e;
    e.xbar  = (s.owner < 0) ? 5'b0 : 5'(1 << s.owner);
    e.rts   = s.rts;
    e.grant = (s.rts && d) ? e.xbar : 5'b0;
    e.idx   = (s.owner < 0) ? 3'd0 : 3'(s.owner);
    return e;
  endfunction

  task automatic compare_pop();
    exp_t e;
    if (q_a.size() == 0 || q_b.size() == 0) begin
      check_eq("sb.empty", 32'(q_a.size() + q_b.size()), 32'd2);
      return;
    end
    e = q_a.pop_front();
    check_eq("a.xbar",  32'(xbar_a),  32'(e.xbar));
    check_eq("a.grant", 32'(grant_a), 32'(e.grant));
    check_eq("a.rts",   32'(rts_a),   32'(e.rts));
    check_eq("a.idx",   32'(idx_a),   32'(e.idx));
    e = q_b.pop_front();
    check_eq("b.xbar",  32'(xbar_b),  32'(e.xbar));
    check_eq("b.grant", 32'(grant_b), 32'(e.grant));
    check_eq("b.rts",   32'(rts_b),   32'(e.rts));
    check_eq("b.idx",   32'(idx_b),   32'(e.idx));
  endtask

  // One cycle: drive at negedge, push expectations, compare mid-cycle, advance the model.
  task automatic step(input logic [4:0] r, input logic d);
    @(negedge clk);
    req  = r;
    dcts = d;
    if (!rst_n) begin
      st_a = m_reset();
      st_b = m_reset();
    end
    #1;
    q_a.push_back(m_out(st_a, d));
    q_b.push_back(m_out(st_b, d));
    #1;
    compare_pop();
    if (!rst_n) begin
      st_a = m_reset();
      st_b = m_reset();
    end else begin
      st_a = m_next(st_a, r, d, 0, 0);
      st_b = m_next(st_b, r, d, 2, 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step(5'b0, 1'b0);
    step(5'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g1, g2, b0, b1;
    logic [4:0] rr;
    st_a = m_reset();
    st_b = m_reset();

    // Reset state and plain toggling ownership of port 1.
    do_reset();
    g1 = 0;
    g2 = 0;
    for (int i = 0; i < 10; i++) begin
      step(5'b00110, 1'b1);
      if (i == 1) check_eq("t2.xbar_cycle1", 32'(xbar_a), 32'h02);
      g1 += int'(grant_a[1]);
      g2 += int'(grant_a[2]);
    end
    check_eq("t2.grant1_count", 32'(g1), 32'd5);
    check_eq("t2.grant2_count", 32'(g2), 32'd0);

    // Hold limit of 2 with streaming: owners alternate every two grants.
    do_reset();
    b0 = 0;
    b1 = 0;
    for (int i = 0; i < 9; i++) begin
      step(5'b00011, 1'b1);
      b0 += int'(grant_b[0]);
      b1 += int'(grant_b[1]);
    end
    check_eq("t3.grant0_count", 32'(b0), 32'd4);
    check_eq("t3.grant1_count", 32'(b1), 32'd4);

    // Stall: owner 3 frozen while DCTS is low and req moves elsewhere.
    do_reset();
    step(5'b01000, 1'b0);
    for (int i = 0; i < 4; i++) step(5'b00001, 1'b0);
    check_eq("t4.stall_idx", 32'(idx_a), 32'd3);
    check_eq("t4.stall_rts", 32'(rts_a), 32'd1);
    step(5'b00001, 1'b1);
    check_eq("t4.release_grant", 32'(grant_a), 32'h08);
    step(5'b00001, 1'b1);
    check_eq("t4.new_owner", 32'(idx_a), 32'd0);

    // Wrap from port 4 to port 0, then all requests drop, then pointer moved past 0.
    do_reset();
    step(5'b10000, 1'b0);
    step(5'b00101, 1'b1);
    check_eq("t5.grant4", 32'(grant_a), 32'h10);
    step(5'b00101, 1'b1);
    check_eq("t5.wrap_idx", 32'(idx_a), 32'd0);
    check_eq("t5.rr_ptr", 32'(dut_a.rr_ptr_q), 32'd0);
    step(5'b00101, 1'b1);
    step(5'b00000, 1'b1);
    step(5'b00000, 1'b1);
    check_eq("t6.idle_xbar", 32'(xbar_a), 32'd0);
    check_eq("t6.idle_rts", 32'(rts_a), 32'd0);
    step(5'b00101, 1'b1);
    step(5'b00101, 1'b1);
    check_eq("t6.next_idx", 32'(idx_a), 32'd2);

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    step(5'b00100, 1'b1);
    @(negedge clk);
    #1;
    check_eq("t1.pre_grant", 32'(grant_a), 32'h04);
    rst_n = 1'b0;
    #1;
    check_eq("t1.grant_a", 32'(grant_a), 32'd0);
    check_eq("t1.xbar_a",  32'(xbar_a),  32'd0);
    check_eq("t1.rts_a",   32'(rts_a),   32'd0);
    check_eq("t1.idx_a",   32'(idx_a),   32'd0);
    check_eq("t1.rts_b",   32'(rts_b),   32'd0);
    check_eq("t1.xbar_b",  32'(xbar_b),  32'd0);
    st_a = m_reset();
    st_b = m_reset();
    step(5'b0, 1'b0);
    rst_n = 1'b1;

    // Random traffic with sticky requests so hold limits and stalls interact.
    rr = 5'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 5'($urandom_range(0, 31));
      step(rr, ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
